// File: rtl/ga_pkg.sv
// ga_pkg
//   Shared constants and state encoding for the GA population-sort path.
//   POP_SIZE : individuals per generation
//   DIST_W   : bits per fitness distance
//   IDX_W    : bits per individual index
//   TIMEOUT  : max cycles spent waiting on the sorter before giving up
package ga_pkg;

    localparam int POP_SIZE = 50;
    localparam int DIST_W   = 12;
    localparam int IDX_W    = 6;
    localparam int TIMEOUT  = 255;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4
    } drv_state_t;

endpackage

// File: rtl/pop_rank_buffer.sv
// pop_rank_buffer
//   Holds the sorter's ranked index list so the sorter is free once done is seen.
//   clk     : clock, rising edge
//   reset   : synchronous, active-high; clears every slot
//   load    : capture sorted into all slots this cycle
//   sorted  : ranked indices, rank r at [IDX_W*r +: IDX_W]
//   rd_idx  : rank to read
//   rd_data : index stored at rank rd_idx (0 when rd_idx is past the last rank)
module pop_rank_buffer #(
    parameter int POP_SIZE = ga_pkg::POP_SIZE,
    parameter int IDX_W    = ga_pkg::IDX_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [POP_SIZE*IDX_W-1:0] sorted,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [IDX_W-1:0]          rd_data
);
    import ga_pkg::*;

    // Packed layout matches the flat bus: slot r occupies bits [IDX_W*r +: IDX_W].
    logic [POP_SIZE-1:0][IDX_W-1:0] slot_q;

    always_ff @(posedge clk) begin
        if (reset)
            slot_q <= '0;
        else if (load)
            slot_q <= sorted;
    end

    // The top reads one rank ahead, so rd_idx can sit one past the end.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < POP_SIZE)
            rd_data = slot_q[rd_idx];
    end

endmodule

// File: rtl/pop_sort_driver.sv
// pop_sort_driver
//   Initiator for the population sorter: gathers one distance per individual from a
//   valid/ready stream, packs them onto the sorter bus, pulses start, waits for done,
//   buffers the ranked indices and replays them best-first on a second stream.
//   clk, reset          : clock / synchronous active-high reset
//   dist_valid/ready/data : inbound distance stream, individual dist_count per beat
//   sort_in             : packed distances, individual i at [DIST_W*i +: DIST_W]
//   sort_start          : one-cycle start pulse to the sorter
//   sort_done           : sorter finished (level)
//   sort_sorted         : ranked indices, rank r at [IDX_W*r +: IDX_W]
//   rank_valid/ready/index/last : outbound ranked-index stream, rank 0 first
//   busy                : not idle
//   error               : sticky sorter timeout flag, cleared only by reset
module pop_sort_driver #(
    parameter int POP_SIZE = ga_pkg::POP_SIZE,
    parameter int DIST_W   = ga_pkg::DIST_W,
    parameter int IDX_W    = ga_pkg::IDX_W,
    parameter int TIMEOUT  = ga_pkg::TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dist_valid,
    output logic                       dist_ready,
    input  logic [DIST_W-1:0]          dist_data,
    output logic [POP_SIZE*DIST_W-1:0] sort_in,
    output logic                       sort_start,
    input  logic                       sort_done,
    input  logic [POP_SIZE*IDX_W-1:0]  sort_sorted,
    output logic                       rank_valid,
    input  logic                       rank_ready,
    output logic [IDX_W-1:0]           rank_index,
    output logic                       rank_last,
    output logic                       busy,
    output logic                       error
);
    import ga_pkg::*;

    // The wait counter must reach TIMEOUT, which does not fit in IDX_W bits.
    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(POP_SIZE - 1);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(TIMEOUT - 1);

    drv_state_t        state;
    logic [IDX_W-1:0]  dist_count;
    logic [IDX_W-1:0]  rank_count;
    logic [WAIT_W-1:0] wait_cnt;
    logic [IDX_W-1:0]  next_rank;
    logic [IDX_W-1:0]  buf_data;
    logic              buf_load;
    logic              dist_hs;
    logic              rank_hs;

    assign dist_hs   = dist_valid & dist_ready;
    assign rank_hs   = rank_valid & rank_ready;
    assign next_rank = rank_count + IDX_W'(1);
    assign buf_load  = (state == S_WAIT) & sort_done;
    assign busy      = (state != S_IDLE);

    // rank_index is registered, so the buffer is read one rank ahead of rank_count.
    pop_rank_buffer #(
        .POP_SIZE (POP_SIZE),
        .IDX_W    (IDX_W)
    ) u_rank_buf (
        .clk     (clk),
        .reset   (reset),
        .load    (buf_load),
        .sorted  (sort_sorted),
        .rd_idx  (next_rank),
        .rd_data (buf_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            dist_count <= '0;
            rank_count <= '0;
            wait_cnt   <= '0;
            sort_in    <= '0;
            dist_ready <= 1'b0;
            sort_start <= 1'b0;
            rank_valid <= 1'b0;
            rank_index <= '0;
            rank_last  <= 1'b0;
            error      <= 1'b0;
        end else begin
            sort_start <= 1'b0;
            case (state)
                // IDLE and LOAD share the accept path; the first beat in IDLE is slot 0
                // because dist_count is always 0 there.
                S_IDLE, S_LOAD: begin
                    dist_ready <= 1'b1;
                    if (dist_hs) begin
                        sort_in[DIST_W*int'(dist_count) +: DIST_W] <= dist_data;
                        if (dist_count == LAST_IDX) begin
                            state      <= S_START;
                            dist_count <= '0;
                            dist_ready <= 1'b0;
                            sort_start <= 1'b1;
                        end else begin
                            state      <= S_LOAD;
                            dist_count <= dist_count + IDX_W'(1);
                        end
                    end
                end

                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end

                S_WAIT: begin
                    if (sort_done) begin
                        // Rank 0 comes straight off the sorter bus; the buffer
                        // captures on this same edge.
                        state      <= S_EMIT;
                        rank_count <= '0;
                        rank_valid <= 1'b1;
                        rank_index <= sort_sorted[IDX_W-1:0];
                        rank_last  <= (POP_SIZE == 1);
                    end else if (wait_cnt == WAIT_END) begin
                        state      <= S_IDLE;
                        error      <= 1'b1;
                        dist_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_EMIT: begin
                    if (rank_hs) begin
                        if (rank_count == LAST_IDX) begin
                            state      <= S_IDLE;
                            rank_count <= '0;
                            rank_valid <= 1'b0;
                            rank_index <= '0;
                            rank_last  <= 1'b0;
                            dist_ready <= 1'b1;
                        end else begin
                            rank_count <= next_rank;
                            rank_index <= buf_data;
                            rank_last  <= (next_rank == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
